// File: rtl/spi_result_tx_if.sv
// rtl/spi_result_tx_if.sv - result handshake bundle between the ALU side and the SPI result transmitter
interface spi_result_tx_if;
    logic       res_valid;
    logic       res_ready;
    logic [7:0] result;
    logic [3:0] flags;
    logic [1:0] opcode;

    // ALU side offers results
    modport master (
        output res_valid,
        output result,
        output flags,
        output opcode,
        input  res_ready
    );

    // transmitter side accepts results into its holding buffer
    modport slave (
        input  res_valid,
        input  result,
        input  flags,
        input  opcode,
        output res_ready
    );
endinterface

// File: rtl/spi_result_tx.sv
// rtl/spi_result_tx.sv - SPI mode-0 slave transmitter returning packed ALU results over MISO
module spi_result_tx #(
    parameter int SYNC_STAGES = 2
) (
    input  logic           clk,
    input  logic           reset_n,
    spi_result_tx_if.slave res_if,
    input  logic           spi_sclk_i,
    input  logic           spi_cs_n_i,
    output logic           spi_miso_o,
    output logic           spi_miso_oe_o,
    output logic           frame_done_o,
    output logic           underrun_o,
    output logic           frame_abort_o
);

    typedef enum logic [1:0] {
        SYNC_WAIT = 2'd0,
        IDLE      = 2'd1,
        SHIFT     = 2'd2,
        DONE      = 2'd3
    } state_t;

    localparam int SETTLE_W = $clog2(SYNC_STAGES + 1);
    localparam logic [SETTLE_W-1:0] SETTLE_MAX = SETTLE_W'(SYNC_STAGES);

    // Frame layout: result, flags, opcode, even parity over those 14 bits, valid marker.
    function automatic logic [15:0] pack_frame(input logic [7:0] r,
                                               input logic [3:0] f,
                                               input logic [1:0] o);
        logic [13:0] body;
        body = {r, f, o};
        return {body, ^body, 1'b1};
    endfunction

    // synchronizers and previous-value registers for edge detection
    logic [SYNC_STAGES-1:0] sclk_sync_q;
    logic [SYNC_STAGES-1:0] cs_sync_q;
    logic                   sclk_prev_q;
    logic                   cs_prev_q;
    logic                   sclk_s;
    logic                   cs_s;
    logic                   sclk_rise;
    logic                   sclk_fall;
    logic                   cs_fall;
    logic                   cs_rise;

    // holding buffer
    logic                   buf_full_q;
    logic                   buf_full_d;
    logic [15:0]            buf_frame_q;
    logic [15:0]            buf_frame_d;
    logic                   load;
    logic                   take;

    // transmit state
    state_t                 state_q;
    logic [15:0]            shift_reg_q;
    logic [4:0]             bit_cnt_q;
    logic [SETTLE_W-1:0]    settle_cnt_q;
    logic                   miso_q;
    logic                   miso_oe_q;
    logic                   frame_done_q;
    logic                   underrun_q;
    logic                   frame_abort_q;

    // Sync flops reset high so a released reset looks like an idle, deselected bus.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sclk_sync_q <= '1;
            cs_sync_q   <= '1;
            sclk_prev_q <= 1'b1;
            cs_prev_q   <= 1'b1;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], spi_sclk_i};
            cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], spi_cs_n_i};
            sclk_prev_q <= sclk_s;
            cs_prev_q   <= cs_s;
        end
    end

    assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
    assign cs_s      = cs_sync_q[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_prev_q;
    assign sclk_fall = ~sclk_s & sclk_prev_q;
    assign cs_fall   = ~cs_s & cs_prev_q;
    assign cs_rise   = cs_s & ~cs_prev_q;

    // A frame start consumes the buffer only if it was already full; a load in
    // the same cycle therefore lands in the buffer for the following frame.
    assign take = (state_q == IDLE) && cs_fall && buf_full_q;
    assign load = res_if.res_valid && !buf_full_q;

    assign res_if.res_ready = !buf_full_q;

    // next-state for the holding buffer; load and take are mutually exclusive
    always_comb begin
        buf_full_d  = buf_full_q;
        buf_frame_d = buf_frame_q;
        if (load) begin
            buf_full_d  = 1'b1;
            buf_frame_d = pack_frame(res_if.result, res_if.flags, res_if.opcode);
        end else if (take) begin
            buf_full_d  = 1'b0;
        end
    end

    // holding buffer registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            buf_full_q  <= 1'b0;
            buf_frame_q <= 16'h0000;
        end else begin
            buf_full_q  <= buf_full_d;
            buf_frame_q <= buf_frame_d;
        end
    end

    // transmit FSM with registered MISO, output enable and event pulses
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= SYNC_WAIT;
            shift_reg_q   <= 16'h0000;
            bit_cnt_q     <= 5'd0;
            settle_cnt_q  <= '0;
            miso_q        <= 1'b0;
            miso_oe_q     <= 1'b0;
            frame_done_q  <= 1'b0;
            underrun_q    <= 1'b0;
            frame_abort_q <= 1'b0;
        end else begin
            frame_done_q  <= 1'b0;
            underrun_q    <= 1'b0;
            frame_abort_q <= 1'b0;
            miso_oe_q     <= (state_q != SYNC_WAIT) && !cs_s;

            case (state_q)
                SYNC_WAIT: begin
                    // Wait until the chain holds real pin samples, then for a
                    // deselected bus, so a CS_N held low through reset is ignored.
                    miso_q <= 1'b0;
                    if (settle_cnt_q != SETTLE_MAX) begin
                        settle_cnt_q <= settle_cnt_q + 1'b1;
                    end else if (cs_s) begin
                        state_q <= IDLE;
                    end
                end

                IDLE: begin
                    miso_q <= 1'b0;
                    if (cs_fall) begin
                        shift_reg_q <= buf_full_q ? buf_frame_q : 16'h0000;
                        underrun_q  <= !buf_full_q;
                        bit_cnt_q   <= 5'd0;
                        state_q     <= SHIFT;
                    end
                end

                SHIFT: begin
                    miso_q <= shift_reg_q[15];
                    if (cs_rise) begin
                        frame_abort_q <= 1'b1;
                        miso_q        <= 1'b0;
                        state_q       <= IDLE;
                    end else if (sclk_rise) begin
                        bit_cnt_q <= bit_cnt_q + 5'd1;
                        if (bit_cnt_q == 5'd15) begin
                            frame_done_q <= 1'b1;
                            miso_q       <= 1'b0;
                            state_q      <= DONE;
                        end
                    end else if (sclk_fall && (bit_cnt_q < 5'd16)) begin
                        shift_reg_q <= {shift_reg_q[14:0], 1'b0};
                    end
                end

                DONE: begin
                    // surplus clocks read zeros until the master deselects
                    miso_q <= 1'b0;
                    if (cs_rise) begin
                        state_q <= IDLE;
                    end
                end

                default: begin
                    miso_q  <= 1'b0;
                    state_q <= SYNC_WAIT;
                end
            endcase
        end
    end

    assign spi_miso_o    = miso_q;
    assign spi_miso_oe_o = miso_oe_q;
    assign frame_done_o  = frame_done_q;
    assign underrun_o    = underrun_q;
    assign frame_abort_o = frame_abort_q;

endmodule

// File: tb/tb_spi_result_tx.sv
// tb/tb_spi_result_tx.sv - scoreboard bench for the SPI result transmitter
module tb_spi_result_tx;

    logic clk;
    logic reset_n;
    logic spi_sclk;
    logic spi_cs_n;
    logic spi_miso;
    logic spi_miso_oe;
    logic frame_done;
    logic underrun;
    logic frame_abort;

    spi_result_tx_if ifc ();

    spi_result_tx #(.SYNC_STAGES(2)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .res_if        (ifc),
        .spi_sclk_i    (spi_sclk),
        .spi_cs_n_i    (spi_cs_n),
        .spi_miso_o    (spi_miso),
        .spi_miso_oe_o (spi_miso_oe),
        .frame_done_o  (frame_done),
        .underrun_o    (underrun),
        .frame_abort_o (frame_abort)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] frame;
        int          nbits;
        bit          chk_bits;
        int          done;
        int          under;
        int          abort;
    } exp_t;

    exp_t exp_q[$];

    int checks = 0;
    int errors = 0;
    int cnt_done = 0;
    int cnt_under = 0;
    int cnt_abort = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
        end
    endtask

    task automatic push_exp(input logic [15:0] frame, input int nbits, input bit chk_bits,
                            input int done, input int under, input int abort);
        exp_t e;
        e.frame    = frame;
        e.nbits    = nbits;
        e.chk_bits = chk_bits;
        e.done     = done;
        e.under    = under;
        e.abort    = abort;
        exp_q.push_back(e);
    endtask

    // pulse counters
    always @(negedge clk) begin
        if (frame_done === 1'b1)  cnt_done++;
        if (underrun === 1'b1)    cnt_under++;
        if (frame_abort === 1'b1) cnt_abort++;
    end

    // monitor: collect MISO per CS_N-low window and compare against the scoreboard
    initial begin
        logic rx[64];
        int   n;
        bit   oe_bad;
        int   s_done, s_under, s_abort;
        int   m;
        logic [15:0] w, ew;
        int   extra_bad;
        exp_t e;
        forever begin
            @(negedge spi_cs_n);
            s_done  = cnt_done;
            s_under = cnt_under;
            s_abort = cnt_abort;
            n = 0;
            oe_bad = 0;
            forever begin
                @(posedge spi_sclk or posedge spi_cs_n);
                if (spi_cs_n) break;
                if (n < 64) rx[n] = spi_miso;
                n++;
                if (spi_miso_oe !== 1'b1) oe_bad = 1;
            end
            repeat (8) @(negedge clk);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_frame: got %0d bits expected no frame", n);
            end else begin
                e = exp_q.pop_front();
                chk("frame_nbits", n, e.nbits);
                if (e.chk_bits) begin
                    m = (n < 16) ? n : 16;
                    w = 16'h0000;
                    for (int i = 0; i < m; i++) w = {w[14:0], rx[i]};
                    ew = e.frame >> (16 - m);
                    chk("frame_bits", w, ew);
                    chk("miso_oe_during_frame", oe_bad, 0);
                    if (n > 16) begin
                        extra_bad = 0;
                        for (int i = 16; i < n && i < 64; i++) if (rx[i] !== 1'b0) extra_bad++;
                        chk("extra_bits_zero", extra_bad, 0);
                    end
                end
                chk("frame_done_count", cnt_done - s_done, e.done);
                chk("underrun_count", cnt_under - s_under, e.under);
                chk("frame_abort_count", cnt_abort - s_abort, e.abort);
            end
        end
    end

    task automatic load(input logic [7:0] r, input logic [3:0] f, input logic [1:0] o);
        bit ok;
        ok = 0;
        @(negedge clk);
        ifc.res_valid = 1'b1;
        ifc.result    = r;
        ifc.flags     = f;
        ifc.opcode    = o;
        for (int i = 0; i < 3000; i++) begin
            if (ifc.res_ready === 1'b1) begin
                ok = 1;
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
        ifc.res_valid = 1'b0;
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL load_timeout: got no res_ready expected acceptance of 0x%0h", r);
        end
    endtask

    task automatic sclk_cycles(input int n);
        repeat (n) begin
            spi_sclk = 1'b1;
            repeat (8) @(negedge clk);
            spi_sclk = 1'b0;
            repeat (8) @(negedge clk);
        end
    endtask

    task automatic run_frame(input int n);
        @(negedge clk);
        spi_cs_n = 1'b0;
        repeat (8) @(negedge clk);
        sclk_cycles(n);
        spi_cs_n = 1'b1;
        repeat (24) @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int bad;
        reset_n       = 1'b0;
        spi_sclk      = 1'b0;
        spi_cs_n      = 1'b1;
        ifc.res_valid = 1'b0;
        ifc.result    = 8'h00;
        ifc.flags     = 4'h0;
        ifc.opcode    = 2'b00;
        repeat (4) @(negedge clk);
        chk("reset_res_ready", ifc.res_ready, 1);
        chk("reset_miso", spi_miso, 0);
        chk("reset_miso_oe", spi_miso_oe, 0);
        chk("reset_pulses", {frame_done, underrun, frame_abort}, 0);
        reset_n = 1'b1;
        repeat (10) @(negedge clk);

        // 1: single result
        load(8'h2D, 4'b0010, 2'b10);
        chk("ready_low_after_load", ifc.res_ready, 0);
        push_exp(16'h2D29, 16, 1, 1, 0, 0);
        fork
            run_frame(16);
            begin
                repeat (14) @(negedge clk);
                chk("ready_high_after_cs_fall", ifc.res_ready, 1);
            end
        join

        // 2: idle frame
        push_exp(16'h0000, 16, 1, 1, 1, 0);
        run_frame(16);

        // 3: back-to-back, second result stalls until the frame starts
        load(8'h0F, 4'h0, 2'b00);
        push_exp(16'h0F01, 16, 1, 1, 0, 0);
        push_exp(16'h902F, 16, 1, 1, 0, 0);
        fork
            load(8'h90, 4'h2, 2'b11);
            begin
                repeat (20) @(negedge clk);
                chk("ready_low_while_full", ifc.res_ready, 0);
                run_frame(16);
            end
        join
        run_frame(16);

        // 4: abort after 7 clocks, result discarded
        load(8'hA5, 4'h1, 2'b01);
        push_exp(16'hA515, 7, 1, 0, 0, 1);
        run_frame(7);
        push_exp(16'h0000, 16, 1, 1, 1, 0);
        run_frame(16);

        // 5: reset mid-frame with CS_N held low
        load(8'h33, 4'h0, 2'b00);
        push_exp(16'h3301, 12, 0, 0, 0, 0);
        @(negedge clk);
        spi_cs_n = 1'b0;
        repeat (8) @(negedge clk);
        load(8'h44, 4'h0, 2'b00);
        sclk_cycles(9);
        reset_n = 1'b0;
        #1;
        chk("midreset_miso", spi_miso, 0);
        chk("midreset_miso_oe", spi_miso_oe, 0);
        chk("midreset_res_ready", ifc.res_ready, 1);
        repeat (4) @(negedge clk);
        reset_n = 1'b1;
        repeat (8) @(negedge clk);
        bad = 0;
        repeat (3) begin
            spi_sclk = 1'b1;
            repeat (8) @(negedge clk);
            if (spi_miso !== 1'b0 || spi_miso_oe !== 1'b0) bad++;
            spi_sclk = 1'b0;
            repeat (8) @(negedge clk);
        end
        chk("no_frame_after_reset", bad, 0);
        spi_cs_n = 1'b1;
        repeat (24) @(negedge clk);
        load(8'h2D, 4'b0010, 2'b10);
        push_exp(16'h2D29, 16, 1, 1, 0, 0);
        run_frame(16);

        // 6: surplus clocks read zero
        load(8'hC3, 4'b1001, 2'b01);
        push_exp(16'hC397, 20, 1, 1, 0, 0);
        run_frame(20);

        repeat (50) @(negedge clk);
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
